// File: rtl/flags_pkg.sv
// Shared constants for the 8086-style FLAGS register: bit positions, the
// update-mask layout, the flag_op encoding and the reserved-bit constants.
package flags_pkg;

  localparam int CF_BIT = 0;
  localparam int PF_BIT = 2;
  localparam int AF_BIT = 4;
  localparam int ZF_BIT = 6;
  localparam int SF_BIT = 7;
  localparam int TF_BIT = 8;
  localparam int IF_BIT = 9;
  localparam int DF_BIT = 10;
  localparam int OF_BIT = 11;

  // upd_mask bit order is {OF,SF,ZF,AF,PF,CF}
  localparam int M_CF = 0;
  localparam int M_PF = 1;
  localparam int M_AF = 2;
  localparam int M_ZF = 3;
  localparam int M_SF = 4;
  localparam int M_OF = 5;

  typedef enum logic [2:0] {
    FOP_NOP = 3'd0,
    FOP_CLC = 3'd1,
    FOP_STC = 3'd2,
    FOP_CMC = 3'd3,
    FOP_CLD = 3'd4,
    FOP_STD = 3'd5,
    FOP_CLI = 3'd6,
    FOP_STI = 3'd7
  } flag_op_e;

  localparam logic [15:0] FLAGS_RESERVED_ONES  = 16'hF002;
  localparam logic [15:0] FLAGS_RESERVED_ZEROS = 16'h0028;
  localparam logic [15:0] FLAGS_RST            = 16'hF002;

  function automatic logic [15:0] fix_reserved(input logic [15:0] f);
    return (f | FLAGS_RESERVED_ONES) & ~FLAGS_RESERVED_ZEROS;
  endfunction

endpackage

// File: rtl/flags_stack.sv
// Small LIFO of 16-bit flag words. Simultaneous push+pop is a no-op; the
// parent decides what that means. ovf/udf pulse on the rejected request.
module flags_stack #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [15:0]   din,
  output logic [15:0]   top,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          udf
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]   mem_q [DEPTH];
  logic [LW-1:0] level_q, level_d;
  logic          full_q, empty_q, do_push, do_pop;

  assign do_push = push & ~pop & ~full_q;
  assign do_pop  = pop & ~push & ~empty_q;
  assign ovf     = push & ~pop & full_q;
  assign udf     = pop & ~push & empty_q;
  assign top     = mem_q[IW'(level_q - LW'(1))];
  assign level   = level_q;
  assign full    = full_q;
  assign empty   = empty_q;

  always_comb begin
    level_d = level_q;
    if (do_push)     level_d = level_q + LW'(1);
    else if (do_pop) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[IW'(level_q)] <= din;
  end

endmodule

// File: rtl/flags_unit.sv
// 8086-style FLAGS register: ALU flag update, flag_op control ops, POPF load
// and an interrupt save/restore LIFO with a sticky stack error.
module flags_unit
  import flags_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_W-1:0]                  alu_result,
  input  logic                               carry_in,
  input  logic                               overflow_in,
  input  logic                               aux_carry_in,
  input  logic                               byte_op,
  input  logic [5:0]                         upd_mask,
  input  logic [2:0]                         flag_op,
  input  logic                               load_en,
  input  logic [15:0]                        load_data,
  input  logic                               int_entry,
  input  logic                               pop,
  input  logic                               err_clr,
  output logic [15:0]                        flags_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               stack_err
);
  localparam int LW = $clog2(STACK_DEPTH + 1);

  logic [15:0] flags_q, flags_d, alu_f, top;
  logic        err_q, err_d, ovf, udf, collide, narrow, zf, sf;

  assign collide = int_entry & pop;
  assign narrow  = byte_op | (DATA_W == 8);
  assign zf      = narrow ? (alu_result[7:0] == 8'h00) : (alu_result == '0);
  assign sf      = narrow ? alu_result[7] : alu_result[DATA_W-1];

  flags_stack #(.DEPTH(STACK_DEPTH), .LW(LW)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (int_entry & ~pop),
    .pop   (pop & ~int_entry),
    .din   (flags_q),
    .top   (top),
    .level (stack_level),
    .full  (stack_full),
    .empty (stack_empty),
    .ovf   (ovf),
    .udf   (udf)
  );

  always_comb begin
    alu_f = flags_q;
    if (upd_mask[M_CF]) alu_f[CF_BIT] = carry_in;
    if (upd_mask[M_PF]) alu_f[PF_BIT] = ~^alu_result[7:0];
    if (upd_mask[M_AF]) alu_f[AF_BIT] = aux_carry_in;
    if (upd_mask[M_ZF]) alu_f[ZF_BIT] = zf;
    if (upd_mask[M_SF]) alu_f[SF_BIT] = sf;
    if (upd_mask[M_OF]) alu_f[OF_BIT] = overflow_in;
    // flag_op acts on the post-ALU value, so CMC sees the fresh carry.
    case (flag_op_e'(flag_op))
      FOP_CLC: alu_f[CF_BIT] = 1'b0;
      FOP_STC: alu_f[CF_BIT] = 1'b1;
      FOP_CMC: alu_f[CF_BIT] = ~alu_f[CF_BIT];
      FOP_CLD: alu_f[DF_BIT] = 1'b0;
      FOP_STD: alu_f[DF_BIT] = 1'b1;
      FOP_CLI: alu_f[IF_BIT] = 1'b0;
      FOP_STI: alu_f[IF_BIT] = 1'b1;
      default: ;
    endcase
    if (int_entry) begin
      alu_f[IF_BIT] = 1'b0;
      alu_f[TF_BIT] = 1'b0;
    end

    flags_d = flags_q;
    if (pop) begin
      if (!int_entry && !stack_empty) flags_d = top;
    end else if (load_en) begin
      flags_d = load_data;
    end else begin
      flags_d = alu_f;
    end
    flags_d = fix_reserved(flags_d);

    err_d = err_q & ~err_clr;
    if (collide | ovf | udf) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= FLAGS_RST;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign flags_o   = flags_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_flags_unit.sv
// Bench for flags_unit: directed literal checks plus a randomized run compared
// every cycle against a queue-based behavioural model.
module tb_flags_unit;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] alu_result;
  logic              carry_in, overflow_in, aux_carry_in, byte_op;
  logic [5:0]        upd_mask;
  logic [2:0]        flag_op;
  logic              load_en, int_entry, pop, err_clr;
  logic [15:0]       load_data, flags_o;
  logic [2:0]        stack_level;
  logic              stack_full, stack_empty, stack_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [15:0] m_flags = 16'hF002;
  logic        m_err   = 1'b0;
  logic [15:0] m_stk[$];

  flags_unit #(.DATA_W(DATA_W), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .alu_result(alu_result), .carry_in(carry_in),
    .overflow_in(overflow_in), .aux_carry_in(aux_carry_in), .byte_op(byte_op),
    .upd_mask(upd_mask), .flag_op(flag_op), .load_en(load_en),
    .load_data(load_data), .int_entry(int_entry), .pop(pop), .err_clr(err_clr),
    .flags_o(flags_o), .stack_level(stack_level), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: flags as a 16-bit word, saved words in a queue.
  always @(posedge clk) begin
    logic [15:0] f;
    logic        e;
    logic [7:0]  lo;
    f  = m_flags;
    e  = m_err & ~err_clr;
    lo = alu_result[7:0];
    if (rst) begin
      m_flags = 16'hF002;
      m_stk.delete();
      m_err = 1'b0;
    end else begin
      if (int_entry && pop) e = 1'b1;
      else if (pop) begin
        if (m_stk.size() == 0) e = 1'b1;
        else f = m_stk.pop_back();
      end else begin
        if (int_entry) begin
          if (m_stk.size() >= DEPTH) e = 1'b1;
          else m_stk.push_back(m_flags);
        end
        if (load_en) f = load_data;
        else begin
          if (upd_mask[0]) f[0]  = carry_in;
          if (upd_mask[1]) f[2]  = ($countones(lo) % 2 == 0);
          if (upd_mask[2]) f[4]  = aux_carry_in;
          if (upd_mask[3]) f[6]  = byte_op ? (lo == 8'h00) : (alu_result == 16'h0000);
          if (upd_mask[4]) f[7]  = byte_op ? lo[7] : alu_result[15];
          if (upd_mask[5]) f[11] = overflow_in;
          case (flag_op)
            3'd1: f[0]  = 1'b0;
            3'd2: f[0]  = 1'b1;
            3'd3: f[0]  = ~f[0];
            3'd4: f[10] = 1'b0;
            3'd5: f[10] = 1'b1;
            3'd6: f[9]  = 1'b0;
            3'd7: f[9]  = 1'b1;
            default: ;
          endcase
          if (int_entry) begin f[9] = 1'b0; f[8] = 1'b0; end
        end
      end
      m_flags = (f | 16'hF002) & ~16'h0028;
      m_err   = e;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_flags", flags_o, m_flags);
      chk("model_level", 16'(stack_level), 16'(m_stk.size()));
      chk("model_full",  16'(stack_full),  16'(m_stk.size() == DEPTH));
      chk("model_empty", 16'(stack_empty), 16'(m_stk.size() == 0));
      chk("model_err",   16'(stack_err),   16'(m_err));
    end
  end

  task automatic idle();
    rst = 1'b0; alu_result = '0; carry_in = 1'b0; overflow_in = 1'b0;
    aux_carry_in = 1'b0; byte_op = 1'b0; upd_mask = '0; flag_op = '0;
    load_en = 1'b0; load_data = '0; int_entry = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); tick(); idle();
  endtask

  initial begin
    idle();
    do_reset();
    chk_en = 1'b1;
    chk("rst_flags", flags_o, 16'hF002);
    chk("rst_empty", 16'(stack_empty), 16'h1);
    chk("rst_level", 16'(stack_level), 16'h0);
    chk("rst_err",   16'(stack_err),   16'h0);

    alu_result = 16'h0000; carry_in = 1'b1; upd_mask = 6'h3F; tick(); idle();
    chk("alu_zero", flags_o, 16'hF047);
    alu_result = 16'h8001; upd_mask = 6'h3E; tick(); idle();
    chk("alu_sign_cf_held", flags_o, 16'hF083);

    do_reset();
    alu_result = 16'h1200; upd_mask = 6'h3F; tick(); idle();
    chk("word_nonzero", flags_o, 16'hF006);
    do_reset();
    alu_result = 16'h1200; byte_op = 1'b1; upd_mask = 6'h3F; tick(); idle();
    chk("byte_zero", flags_o, 16'hF046);
    flag_op = 3'd7; tick(); idle();
    chk("sti", flags_o, 16'hF246);
    int_entry = 1'b1; tick(); idle();
    chk("int_entry", flags_o, 16'hF046);
    chk("int_level", 16'(stack_level), 16'h1);
    pop = 1'b1; tick(); idle();
    chk("iret", flags_o, 16'hF246);
    chk("iret_level", 16'(stack_level), 16'h0);
    pop = 1'b1; tick(); idle();
    chk("pop_empty_flags", flags_o, 16'hF246);
    chk("pop_empty_err", 16'(stack_err), 16'h1);
    err_clr = 1'b1; tick(); idle();
    chk("err_clr", 16'(stack_err), 16'h0);
    for (int i = 0; i < DEPTH + 1; i++) begin int_entry = 1'b1; tick(); end
    idle();
    chk("push_full", 16'(stack_full), 16'h1);
    chk("push_ovf_err", 16'(stack_err), 16'h1);
    chk("push_ovf_flags", flags_o, 16'hF046);
    err_clr = 1'b1; tick(); idle();
    chk("err_clr2", 16'(stack_err), 16'h0);
    load_en = 1'b1; load_data = 16'h0000; tick(); idle();
    chk("load_zero", flags_o, 16'hF002);
    int_entry = 1'b1; pop = 1'b1; err_clr = 1'b1; tick(); idle();
    chk("collide_err", 16'(stack_err), 16'h1);
    chk("collide_level", 16'(stack_level), 16'(DEPTH));

    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(63) == 0);
      alu_result   = ($urandom_range(3) == 0) ? 16'($urandom_range(1) << 8) : 16'($urandom);
      carry_in     = 1'($urandom);
      overflow_in  = 1'($urandom);
      aux_carry_in = 1'($urandom);
      byte_op      = 1'($urandom);
      upd_mask     = 6'($urandom);
      flag_op      = ($urandom_range(1) == 0) ? 3'd0 : 3'($urandom);
      int_entry    = ($urandom_range(3) == 0);
      pop          = ($urandom_range(3) == 0);
      load_en      = !int_entry && ($urandom_range(5) == 0);
      load_data    = 16'($urandom);
      err_clr      = ($urandom_range(7) == 0);
      tick();
    end
    idle();
    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
